shift_exec_stage: RTL and testbench

//  Registered shift/rotate execution stage of the EX unit. Accepts decoded shift ops over a

---
 rtl/shift_exec_stage.sv | 207 ++++++++++++++++++++
 tb/tb_shift_exec_stage.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_exec_stage.sv
// shift_exec_stage
//   Registered shift/rotate execution stage. Decoded shift ops arrive over a
//   valid/ready handshake and drive a shared combinational 64-bit shifter core.
//   The core's typ encoding is 00/01 left, 10 right zero-fill, 11 right arithmetic.
//   RV64 word forms and two-pass rotates are built on top of that core. The
//   result is registered toward writeback, and one result is held while the
//   consumer applies backpressure.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   flush      synchronous kill of the in-flight and held op
//   in_valid   op presented
//   in_ready   stage can accept an op this cycle
//   in_op      000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 reserved
//   in_w       word form (ignored for rotates)
//   in_src     64-bit operand
//   in_shamt   shift amount (bit 5 masked for word forms)
//   in_tag     tag, returned unchanged with the result
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out_data   result
//   out_tag    tag of the result
//   out_err    op was reserved or illegal; out_data is then 0
module shift_exec_stage #(
  parameter int TAG_W  = 5,
  parameter bit ROT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_w,
  input  logic [63:0]      in_src,
  input  logic [5:0]       in_shamt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int DATA_W = 64;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROT2 = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] data_p1;
  logic [TAG_W-1:0]  tag_p1;
  logic              err_p1;
  logic              vld_p1;

  // Rotate context carried from pass 1 into pass 2.
  logic [DATA_W-1:0] tmp_p1;
  logic [DATA_W-1:0] src_p1;
  logic [5:0]        n_p1;
  logic              rol_p1;
  logic [TAG_W-1:0]  rtag_p1;

  logic              accept;
  logic              is_rot;
  logic              is_rsv;
  logic              rot_pass;
  logic [DATA_W-1:0] core_din;
  logic [1:0]        core_typ;
  logic [5:0]        core_num;
  logic [DATA_W-1:0] core_out;
  logic [DATA_W-1:0] simple_res;

  function automatic logic [DATA_W-1:0] shift_core(input logic [DATA_W-1:0] din,
                                                   input logic [1:0]        typ,
                                                   input logic [5:0]        num);
    logic signed [DATA_W-1:0] sdin;
    sdin = $signed(din);
    case (typ)
      2'b10:   shift_core = din >> num;
      2'b11:   shift_core = $unsigned(sdin >>> num);
      default: shift_core = din << num;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] sext_word(input logic [31:0] r);
    sext_word = {{32{r[31]}}, r};
  endfunction

  assign in_ready = !flush && ((state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready));
  assign accept   = in_valid && in_ready;

  assign is_rot   = (in_op == OP_ROL) || (in_op == OP_ROR);
  assign is_rsv   = (in_op > OP_ROR) || (is_rot && !ROT_EN);
  // A rotate by zero is just the operand and skips the second pass.
  assign rot_pass = is_rot && !is_rsv && (in_shamt != 6'd0);

  // The core is shared: pass 2 of a rotate owns it in ROT2, when nothing can be accepted.
  always_comb begin
    core_din = in_src;
    core_typ = 2'b00;
    core_num = in_shamt;
    if (state_q == S_ROT2) begin
      core_din = src_p1;
      core_typ = rol_p1 ? 2'b10 : 2'b00;
      // 64-n is formed in 7 bits; n is nonzero here, so it always fits in 6.
      core_num = 6'(7'd64 - {1'b0, n_p1});
    end else begin
      case (in_op)
        OP_SRL:  core_typ = 2'b10;
        OP_SRA:  core_typ = 2'b11;
        OP_ROR:  core_typ = 2'b10;
        default: core_typ = 2'b00;
      endcase
      if (in_w && !is_rot) begin
        core_din = (in_op == OP_SRA) ? sext_word(in_src[31:0]) : {32'd0, in_src[31:0]};
        core_num = {1'b0, in_shamt[4:0]};
      end
    end
  end

  assign core_out   = shift_core(core_din, core_typ, core_num);
  assign simple_res = in_w ? sext_word(core_out[31:0]) : core_out;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_HOLD: begin
          if (accept) begin
            state_d = rot_pass ? S_ROT2 : S_HOLD;
          end else if ((state_q == S_HOLD) && out_ready) begin
            state_d = S_IDLE;
          end
        end
        S_ROT2:  state_d = S_HOLD;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---- stage p1: result / rotate-context registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      tag_p1  <= '0;
      err_p1  <= 1'b0;
      tmp_p1  <= '0;
      src_p1  <= '0;
      n_p1    <= '0;
      rol_p1  <= 1'b0;
      rtag_p1 <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        vld_p1 <= 1'b0;
        tmp_p1 <= '0;
      end else if (accept) begin
        if (is_rsv) begin
          vld_p1  <= 1'b1;
          data_p1 <= '0;
          err_p1  <= 1'b1;
          tag_p1  <= in_tag;
        end else if (rot_pass) begin
          vld_p1  <= 1'b0;
          tmp_p1  <= core_out;
          src_p1  <= in_src;
          n_p1    <= in_shamt;
          rol_p1  <= (in_op == OP_ROL);
          rtag_p1 <= in_tag;
        end else begin
          vld_p1  <= 1'b1;
          data_p1 <= is_rot ? in_src : simple_res;
          err_p1  <= 1'b0;
          tag_p1  <= in_tag;
        end
      end else if (state_q == S_ROT2) begin
        vld_p1  <= 1'b1;
        data_p1 <= tmp_p1 | core_out;
        err_p1  <= 1'b0;
        tag_p1  <= rtag_p1;
      end else if ((state_q == S_HOLD) && out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_tag   = tag_p1;
  assign out_err   = err_p1;

endmodule

// File: tb/tb_shift_exec_stage.sv
module tb_shift_exec_stage;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic             in_w;
  logic [63:0]      in_src;
  logic [5:0]       in_shamt;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  always #5 clk = ~clk;

  shift_exec_stage #(.TAG_W(TAG_W), .ROT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_w(in_w),
    .in_src(in_src), .in_shamt(in_shamt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_err(out_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_xfer   = 0;

  typedef struct packed {
    logic [63:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } res_t;

  res_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: what each op means architecturally, in plain arithmetic.
  function automatic res_t model(input logic [2:0] op, input logic w, input logic [63:0] src,
                                 input logic [5:0] sh, input logic [TAG_W-1:0] tag);
    res_t        r;
    logic [31:0] lo;
    int          n;
    r.tag  = tag;
    r.err  = 1'b0;
    r.data = '0;
    lo     = '0;
    n      = int'(sh);
    case (op)
      3'd0: begin
        lo = src[31:0] << sh[4:0];
        r.data = w ? {{32{lo[31]}}, lo} : (src << sh);
      end
      3'd1: begin
        lo = src[31:0] >> sh[4:0];
        r.data = w ? {{32{lo[31]}}, lo} : (src >> sh);
      end
      3'd2: begin
        lo = $signed(src[31:0]) >>> sh[4:0];
        r.data = w ? {{32{lo[31]}}, lo} : $unsigned($signed(src) >>> sh);
      end
      3'd3:    r.data = (src << n) | (src >> (64 - n));
      3'd4:    r.data = (src >> n) | (src << (64 - n));
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  // Scoreboard: all sampling on the falling edge, where inputs and outputs are settled.
  logic             stall_prev = 1'b0;
  logic [63:0]      held_data;
  logic [TAG_W-1:0] held_tag;
  logic             held_err;

  always @(negedge clk) begin
    res_t e;
    if (stall_prev) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_data", out_data, held_data);
      chk("stall_tag", 64'(out_tag), 64'(held_tag));
      chk("stall_err", 64'(out_err), 64'(held_err));
    end
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_result: got out_valid=1 tag=0x%0h, expected no result", out_tag);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", out_data, e.data);
          chk("sb_tag", 64'(out_tag), 64'(e.tag));
          chk("sb_err", 64'(out_err), 64'(e.err));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_op, in_w, in_src, in_shamt, in_tag));
    end
    stall_prev = out_valid && !out_ready && !rst && !flush;
    held_data  = out_data;
    held_tag   = out_tag;
    held_err   = out_err;
  end

  // Present one op and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input logic [2:0] op, input logic w, input logic [63:0] src,
                      input logic [5:0] sh, input logic [TAG_W-1:0] tag);
    bit got;
    got      = 1'b0;
    in_op    = op;
    in_w     = w;
    in_src   = src;
    in_shamt = sh;
    in_tag   = tag;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      @(posedge clk);
      #1;
    end else begin
      n_checks++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected acceptance (op=%0d tag=0x%0h)", op, tag);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected end of test");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  op;
    logic        w;
    logic [63:0] src;
    logic [5:0]  sh;
  } vec_t;

  vec_t vecs[10];
  int   n0;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_w = 1'b0;
    in_src = '0; in_shamt = '0; in_tag = '0; out_ready = 1'b1;

    // Pin the reference model to hand-computed values.
    chk("model_sraw", model(3'd2, 1'b1, 64'h0000_0000_8000_0000, 6'd4, '0).data, 64'hFFFF_FFFF_F800_0000);
    chk("model_rol", model(3'd3, 1'b0, 64'h8000_0000_0000_0001, 6'd4, '0).data, 64'h18);
    chk("model_ror_w", model(3'd4, 1'b1, 64'h1, 6'd1, '0).data, 64'h8000_0000_0000_0000);
    chk("model_srlw", model(3'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, 6'd31, '0).data, 64'h1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;

    send(3'd2, 1'b1, 64'h0000_0000_8000_0000, 6'd4, 5'd1);
    chk("sraw_lat1_valid", 64'(out_valid), 64'd1);
    chk("sraw_data", out_data, 64'hFFFF_FFFF_F800_0000);

    send(3'd0, 1'b1, 64'h0000_0000_4000_0001, 6'd33, 5'd2);
    chk("sllw_data", out_data, 64'hFFFF_FFFF_8000_0002);

    send(3'd3, 1'b0, 64'h8000_0000_0000_0001, 6'd4, 5'd3);
    chk("rol_pass1_novalid", 64'(out_valid), 64'd0);
    chk("rot2_in_ready", 64'(in_ready), 64'd0);
    // Operand changes during ROT2 must not disturb the rotate.
    in_op = 3'd1; in_w = 1'b0; in_src = 64'hF0; in_shamt = 6'd4; in_tag = 5'd4; in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("rol_lat2_valid", 64'(out_valid), 64'd1);
    chk("rol_data", out_data, 64'h18);
    chk("rol_tag", 64'(out_tag), 64'd3);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("srl_after_rot", out_data, 64'hF);

    send(3'd4, 1'b0, 64'h1234_5678_9ABC_DEF0, 6'd0, 5'd5);
    chk("ror0_valid", 64'(out_valid), 64'd1);
    chk("ror0_data", out_data, 64'h1234_5678_9ABC_DEF0);
    @(posedge clk);
    #1;

    // Backpressure on a held result.
    out_ready = 1'b0;
    send(3'd0, 1'b0, 64'h1, 6'd8, 5'd6);
    in_op = 3'd1; in_w = 1'b0; in_src = 64'h100; in_shamt = 6'd8; in_tag = 5'd7; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_data", out_data, 64'h100);
      chk("bp_tag", 64'(out_tag), 64'd6);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_second_data", out_data, 64'h1);
    chk("bp_second_tag", 64'(out_tag), 64'd7);

    // Flush while a rotate is in its second pass.
    send(3'd3, 1'b0, 64'hFF, 6'd8, 5'd8);
    flush = 1'b1;
    in_op = 3'd1; in_w = 1'b0; in_src = 64'hABC0; in_shamt = 6'd4; in_tag = 5'd9; in_valid = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_kill_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("post_flush_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("post_flush_valid", 64'(out_valid), 64'd1);
    chk("post_flush_data", out_data, 64'hABC);
    chk("post_flush_tag", 64'(out_tag), 64'd9);

    // Reserved op, then a legal op clears the error.
    send(3'd6, 1'b0, 64'hDEAD, 6'd3, 5'h1F);
    chk("rsv_valid", 64'(out_valid), 64'd1);
    chk("rsv_err", 64'(out_err), 64'd1);
    chk("rsv_data", out_data, 64'd0);
    chk("rsv_tag", 64'(out_tag), 64'h1F);
    send(3'd1, 1'b0, 64'h80, 6'd3, 5'd1);
    chk("err_clear", 64'(out_err), 64'd0);
    chk("err_clear_data", out_data, 64'h10);
    @(posedge clk);
    #1;

    // Eight back-to-back SRLs, one per cycle.
    n0 = n_xfer;
    for (int i = 0; i < 8; i++) begin
      in_op = 3'd1; in_w = 1'b0; in_src = 64'h8000_0000_0000_0000;
      in_shamt = 6'(i); in_tag = 5'(10 + i); in_valid = 1'b1;
      @(negedge clk);
      chk("b2b_ready", 64'(in_ready), 64'd1);
      if (i > 0) chk("b2b_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_count", 64'(n_xfer - n0), 64'd8);

    // Mixed vectors checked through the scoreboard.
    vecs[0] = '{3'd0, 1'b0, 64'h0123_4567_89AB_CDEF, 6'd63};
    vecs[1] = '{3'd1, 1'b0, 64'h8000_0000_0000_0000, 6'd63};
    vecs[2] = '{3'd2, 1'b0, 64'h8000_0000_0000_0000, 6'd63};
    vecs[3] = '{3'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, 6'd31};
    vecs[4] = '{3'd2, 1'b1, 64'h0000_0000_1234_5678, 6'd36};
    vecs[5] = '{3'd4, 1'b1, 64'h1, 6'd1};
    vecs[6] = '{3'd3, 1'b0, 64'h3, 6'd63};
    vecs[7] = '{3'd2, 1'b0, 64'h7FFF_0000_0000_0001, 6'd1};
    vecs[8] = '{3'd5, 1'b0, 64'h55, 6'd2};
    vecs[9] = '{3'd3, 1'b0, 64'hCAFE, 6'd0};
    for (int i = 0; i < 10; i++) send(vecs[i].op, vecs[i].w, vecs[i].src, vecs[i].sh, 5'(20 + i));
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    // Reset while a result is held.
    out_ready = 1'b0;
    send(3'd0, 1'b0, 64'h1, 6'd1, 5'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_data", out_data, 64'd0);
    chk("midrst_tag", 64'(out_tag), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
